// File: rtl/mriscv_pkg.sv
// Shared RV32I decode constants: opcodes, branch/load/store func3 values,
// the immediate-format enum and the held decode record.
package mriscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic        is_store;
        logic        is_load;
        logic        is_branch;
        logic        is_jump;
        logic        is_reg;
        logic        is_alu;
        logic        func7;
        logic        illegal;
        logic [2:0]  func3;
        logic [4:0]  dest;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] branch_dest;
        logic [31:0] store_data;
        logic [31:0] curr_pc;
    } dec_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {i[31:12], 12'b0};
            IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file: two combinational reads, one synchronous
// write, synchronous clear. x0 is hard-wired to zero.
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) regs_q[r] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode.sv
// RV32I decode stage with a one-deep valid/ready output register.
// Define DECODE_WB_BYPASS_EN to forward same-edge writeback data into operands.
module decode
    import mriscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        in_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        is_store,
    output logic        is_load,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_reg,
    output logic        is_alu,
    output logic        func7,
    output logic        illegal,
    output logic [2:0]  func3,
    output logic [4:0]  dest,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] branch_dest,
    output logic [31:0] store_data,
    output logic [31:0] curr_pc
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rf_rd1, rf_rd2, rs1_val, rs2_val, imm;
    imm_fmt_e    fmt;
    logic        ill, accept;
    dec_t        dec_d, dec_q;
    logic        out_valid_d, out_valid_q;

    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    regfile u_rf (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val = (wb_en && wb_addr != 5'd0 && wb_addr == rs1) ? wb_data : rf_rd1;
    assign rs2_val = (wb_en && wb_addr != 5'd0 && wb_addr == rs2) ? wb_data : rf_rd2;
`else
    assign rs1_val = rf_rd1;
    assign rs2_val = rf_rd2;
`endif

    always_comb begin
        fmt = IMM_NONE;
        case (opc)
            OP_IMM, OP_JALR, OP_LOAD: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
    end

    assign imm = gen_imm(instr, fmt);

    always_comb begin
        ill               = 1'b0;
        dec_d             = '0;
        dec_d.curr_pc     = pc;
        dec_d.func3       = f3;
        case (opc)
            OP_REG: begin
                dec_d.is_alu    = 1'b1;
                dec_d.is_reg    = 1'b1;
                dec_d.func7     = instr[30];
                dec_d.operand_a = rs1_val;
                dec_d.operand_b = rs2_val;
                dec_d.dest      = rd;
            end
            OP_IMM: begin
                dec_d.is_alu    = 1'b1;
                dec_d.func7     = (f3 == F3_SRX) ? instr[30] : 1'b0;
                dec_d.operand_a = rs1_val;
                dec_d.operand_b = imm;
                dec_d.dest      = rd;
            end
            OP_LUI, OP_AUIPC: begin
                dec_d.is_alu    = 1'b1;
                dec_d.func3     = 3'b000;
                dec_d.operand_a = (opc == OP_AUIPC) ? pc : 32'd0;
                dec_d.operand_b = imm;
                dec_d.dest      = rd;
            end
            OP_BRANCH: begin
                ill = !(f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
                dec_d.is_branch   = 1'b1;
                dec_d.operand_a   = rs1_val;
                dec_d.operand_b   = rs2_val;
                dec_d.branch_dest = imm;
            end
            OP_JAL: begin
                dec_d.is_jump   = 1'b1;
                dec_d.operand_a = imm;
                dec_d.dest      = rd;
            end
            OP_JALR: begin
                dec_d.is_jump   = 1'b1;
                dec_d.is_reg    = 1'b1;
                dec_d.operand_a = rs1_val;
                dec_d.operand_b = imm;
                dec_d.dest      = rd;
            end
            OP_LOAD: begin
                ill = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
                dec_d.is_load   = 1'b1;
                dec_d.operand_a = rs1_val;
                dec_d.operand_b = imm;
                dec_d.dest      = rd;
            end
            OP_STORE: begin
                ill = !(f3 inside {F3_SB, F3_SH, F3_SW});
                dec_d.is_store   = 1'b1;
                dec_d.operand_a  = rs1_val;
                dec_d.operand_b  = imm;
                dec_d.store_data = rs2_val;
            end
            default: ill = 1'b1;
        endcase
        // An illegal encoding carries nothing downstream except its pc.
        if (ill) begin
            dec_d         = '0;
            dec_d.illegal = 1'b1;
            dec_d.curr_pc = pc;
        end
    end

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) dec_q <= dec_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign is_store    = dec_q.is_store;
    assign is_load     = dec_q.is_load;
    assign is_branch   = dec_q.is_branch;
    assign is_jump     = dec_q.is_jump;
    assign is_reg      = dec_q.is_reg;
    assign is_alu      = dec_q.is_alu;
    assign func7       = dec_q.func7;
    assign illegal     = dec_q.illegal;
    assign func3       = dec_q.func3;
    assign dest        = dec_q.dest;
    assign operand_a   = dec_q.operand_a;
    assign operand_b   = dec_q.operand_b;
    assign branch_dest = dec_q.branch_dest;
    assign store_data  = dec_q.store_data;
    assign curr_pc     = dec_q.curr_pc;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed instructions with hand-computed
// expectations; a negedge monitor checks every presented output.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
    logic [31:0] instr, pc, wb_data;
    logic [4:0]  wb_addr;
    logic        is_store, is_load, is_branch, is_jump, is_reg, is_alu, func7, illegal;
    logic [2:0]  func3;
    logic [4:0]  dest;
    logic [31:0] operand_a, operand_b, branch_dest, store_data, curr_pc;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
        .in_ready(in_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .is_store(is_store), .is_load(is_load), .is_branch(is_branch), .is_jump(is_jump),
        .is_reg(is_reg), .is_alu(is_alu), .func7(func7), .illegal(illegal),
        .func3(func3), .dest(dest), .operand_a(operand_a), .operand_b(operand_b),
        .branch_dest(branch_dest), .store_data(store_data), .curr_pc(curr_pc)
    );

    typedef struct packed {
        logic        st, ld, br, jmp, rg, alu, f7, ill;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, bd, sd, pc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic exp_t act();
        return {is_store, is_load, is_branch, is_jump, is_reg, is_alu, func7, illegal,
                func3, dest, operand_a, operand_b, branch_dest, store_data, curr_pc};
    endfunction

    function automatic exp_t blank(input logic [31:0] p);
        exp_t e = '0;
        e.pc = p;
        return e;
    endfunction

    task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_out(input string nm, input exp_t e);
        exp_t a = act();
        total++;
        if (out_valid !== 1'b1 || a !== e) begin
            bad++;
            $display("FAIL %s: valid=%b got %h want %h", nm, out_valid, a, e);
        end
    endtask

    task automatic check_idle(input string nm);
        exp_t z = '0;
        chk1({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk1({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
        total++;
        if (act() !== z) begin
            bad++;
            $display("FAIL %s_zero: got %h want %h", nm, act(), z);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none", act());
                end else begin
                    check_out(name_q.pop_front(), exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [31:0] i, input logic [31:0] p, input exp_t e);
        int n = 0;
        in_valid = 1'b1; instr = i; pc = p;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: in_ready=0 want 1", nm);
        end else begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e, ea, eb;
        reset = 1'b1; in_valid = 1'b0; instr = '0; pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_idle("reset");

        wb_write(5'd0, 32'hDEAD);
        wb_write(5'd1, 32'd200);
        wb_write(5'd2, 32'd200);

        e = blank(32'd20); e.br = 1; e.a = 200; e.b = 200; e.bd = 20;
        issue("beq", 32'h00208A63, 32'd20, e);

        wb_write(5'd5, 32'd32);
        e = blank(32'd4); e.jmp = 1; e.rg = 1; e.a = 32; e.b = 16; e.rd = 11;
        issue("jalr", 32'h010285E7, 32'd4, e);

        e = blank(32'h8); e.alu = 1; e.b = 32'h12345000; e.rd = 7;
        issue("lui", 32'h123453B7, 32'h8, e);

        e = blank(32'h100); e.alu = 1; e.a = 32'h100; e.b = 32'hFFFFF000; e.rd = 5;
        issue("auipc", 32'hFFFFF297, 32'h100, e);

        e = blank(32'h104); e.alu = 1; e.f7 = 1; e.f3 = 3'd5; e.a = 32; e.b = 32'h403; e.rd = 4;
        issue("srai", 32'h4032D213, 32'h104, e);

        e = blank(32'h108); e.ld = 1; e.f3 = 3'd2; e.a = 200; e.b = 32'hFFFFFFFC; e.rd = 6;
        issue("lw", 32'hFFC0A303, 32'h108, e);

        e = blank(32'h10C); e.st = 1; e.f3 = 3'd2; e.a = 200; e.b = 8; e.sd = 200;
        issue("sw", 32'h0020A423, 32'h10C, e);

        e = blank(32'h110); e.jmp = 1; e.f3 = 3'd7; e.a = 32'hFFFFFFF8; e.rd = 1;
        issue("jal", 32'hFF9FF0EF, 32'h110, e);

        e = blank(32'h114); e.ill = 1;
        issue("bad_branch_f3", 32'h00002063, 32'h114, e);

        e = blank(32'h118); e.alu = 1; e.rg = 1; e.a = 200; e.b = 0; e.rd = 3;
        issue("add_x0", 32'h000081B3, 32'h118, e);
        tick();

        // Backpressure: A held three cycles while B waits at the input.
        out_ready = 1'b0;
        ea = blank(32'h200); ea.alu = 1; ea.rg = 1; ea.a = 200; ea.b = 200; ea.rd = 3;
        issue("bp_a", 32'h002081B3, 32'h200, ea);
        eb = blank(32'h204); eb.alu = 1; eb.b = 32'h12345000; eb.rd = 7;
        in_valid = 1'b1; instr = 32'h123453B7; pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            chk1("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_out("bp_hold", ea);
            tick();
        end
        out_ready = 1'b1;
        exp_q.push_back(eb);
        name_q.push_back("bp_b");
        tick();
        in_valid = 1'b0;
        check_out("bp_load", eb);

        wb_write(5'd1, 32'd7);
        e = blank(32'h120); e.alu = 1; e.rg = 1; e.rd = 3;
`ifdef DECODE_WB_BYPASS_EN
        e.a = 32'h55;
`else
        e.a = 32'd7;
`endif
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        issue("bypass", 32'h000081B3, 32'h120, e);
        wb_en = 1'b0;
        e = blank(32'h124); e.alu = 1; e.rg = 1; e.rd = 3; e.a = 32'h55;
        issue("wb_landed", 32'h000081B3, 32'h124, e);
        tick();

        // Illegal opcode held, then flushed with a competing input.
        out_ready = 1'b0;
        e = blank(32'h300); e.ill = 1;
        issue("illegal", 32'hFFFFFFFF, 32'h300, e);
        check_out("illegal_held", e);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h000081B3; pc = 32'h304;
        chk1("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk1("flush_valid", {31'd0, out_valid}, 32'd0);
        void'(exp_q.pop_front());
        void'(name_q.pop_front());
        tick();
        chk1("post_flush_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stall drops the held item and ignores same-edge inputs.
        e = blank(32'h400); e.alu = 1; e.rg = 1; e.rd = 3; e.a = 32'h55; e.b = 200;
        issue("pre_reset", 32'h002081B3, 32'h400, e);
        reset = 1'b1; in_valid = 1'b1; instr = 32'h009081B3; pc = 32'h404;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        tick();
        reset = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        exp_q.delete();
        name_q.delete();
        check_idle("midreset");
        out_ready = 1'b1;
        e = blank(32'h500); e.alu = 1; e.rg = 1; e.rd = 3;
        issue("rf_cleared", 32'h009081B3, 32'h500, e);

        tick(); tick();
        chk1("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
